bcd_seg7_scan: RTL

//  - Consumes the packed 2-digit BCD value (00..99) from the binary->BCD converter.
//  - Drives a 2-digit multiplexed 7-segment display: one digit lit per scan slot, alternating tens/units.
//  - valid/ready input with a one-entry pending buffer; new values are applied only at frame boundaries, so a frame never shows mixed digits.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/bcd_seg7_scan_if.sv | 11 +
 rtl/bcd_to_seg7.sv | 26 ++
 rtl/bcd_seg7_scan.sv | 117 +++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 2-digit multiplexed 7-segment scanner:
// scan state encoding and active-high segment codes (gfedcba).
package seg7_pkg;

   typedef enum logic [1:0] {
      ST_BLANK = 2'd0,
      ST_TENS  = 2'd1,
      ST_UNITS = 2'd2
   } state_t;

   localparam logic [6:0] SEG_CODE_0 = 7'h3F;
   localparam logic [6:0] SEG_CODE_1 = 7'h06;
   localparam logic [6:0] SEG_CODE_2 = 7'h5B;
   localparam logic [6:0] SEG_CODE_3 = 7'h4F;
   localparam logic [6:0] SEG_CODE_4 = 7'h66;
   localparam logic [6:0] SEG_CODE_5 = 7'h6D;
   localparam logic [6:0] SEG_CODE_6 = 7'h7D;
   localparam logic [6:0] SEG_CODE_7 = 7'h07;
   localparam logic [6:0] SEG_CODE_8 = 7'h7F;
   localparam logic [6:0] SEG_CODE_9 = 7'h6F;
   localparam logic [6:0] SEG_ERR    = 7'h79;
   localparam logic [6:0] SEG_BLANK  = 7'h00;

endpackage

// File: rtl/bcd_seg7_scan_if.sv
// valid/ready handshake carrying a packed 2-digit BCD value ([7:4] tens, [3:0] units).
interface bcd_seg7_scan_if;

   logic       bcd_valid;
   logic [7:0] packed_bcd;
   logic       bcd_ready;

   modport master (output bcd_valid, output packed_bcd, input bcd_ready);
   modport slave  (input bcd_valid, input packed_bcd, output bcd_ready);

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-high 7-segment code; non-decimal nibbles show 'E'.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] code
);

   always_comb begin
      code = SEG_ERR;
      case (nibble)
         4'd0:    code = SEG_CODE_0;
         4'd1:    code = SEG_CODE_1;
         4'd2:    code = SEG_CODE_2;
         4'd3:    code = SEG_CODE_3;
         4'd4:    code = SEG_CODE_4;
         4'd5:    code = SEG_CODE_5;
         4'd6:    code = SEG_CODE_6;
         4'd7:    code = SEG_CODE_7;
         4'd8:    code = SEG_CODE_8;
         4'd9:    code = SEG_CODE_9;
         default: code = SEG_ERR;
      endcase
   end

endmodule

// File: rtl/bcd_seg7_scan.sv
// 2-digit multiplexed 7-segment scanner with a one-entry pending buffer, updated only at frame boundaries.
// Optional build macro SEG7_LZ_BLANK_EN: blank the tens slot when the tens digit is 0.
module bcd_seg7_scan
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV       = 1000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   bcd_seg7_scan_if.slave   bus,
   output logic [1:0]       an,
   output logic [6:0]       seg
);

   localparam int             CNT_W    = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [1:0]     AN_OFF   = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;
   localparam logic [6:0]     SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

   logic [CNT_W-1:0] count;
   logic             tick;
   state_t           state;
   state_t           state_nxt;
   logic             pend_full;
   logic [7:0]       pend;
   logic [7:0]       disp;
   logic [7:0]       disp_nxt;
   logic             accept;
   logic             transfer;
   logic [3:0]       nibble;
   logic [6:0]       code;
   logic [1:0]       an_raw;
   logic [6:0]       seg_raw;

   assign tick          = (count == CNT_LAST);
   assign bus.bcd_ready = ~pend_full;
   assign accept        = bus.bcd_valid & ~pend_full;
   // Transfers only at a frame boundary (or out of BLANK) so a frame never mixes two values.
   assign transfer      = tick & pend_full & (state != ST_TENS);
   assign disp_nxt      = transfer ? pend : disp;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_BLANK: if (tick && pend_full) state_nxt = ST_TENS;
         ST_TENS:  if (tick) state_nxt = ST_UNITS;
         ST_UNITS: if (tick) state_nxt = ST_TENS;
         default:  state_nxt = ST_BLANK;
      endcase
   end

   assign nibble = (state_nxt == ST_TENS) ? disp_nxt[7:4] : disp_nxt[3:0];

   bcd_to_seg7 u_dec (
      .nibble (nibble),
      .code   (code)
   );

   always_comb begin
      an_raw  = 2'b00;
      seg_raw = SEG_BLANK;
      case (state_nxt)
         ST_TENS: begin
            an_raw  = 2'b10;
            seg_raw = code;
`ifdef SEG7_LZ_BLANK_EN
            if (disp_nxt[7:4] == 4'd0) begin
               an_raw  = 2'b00;
               seg_raw = SEG_BLANK;
            end
`endif
         end
         ST_UNITS: begin
            an_raw  = 2'b01;
            seg_raw = code;
         end
         default: begin
            an_raw  = 2'b00;
            seg_raw = SEG_BLANK;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

   // Pending data needs no reset: pend_full qualifies it.
   always_ff @(posedge clk) begin
      if (accept) pend <= bus.packed_bcd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_BLANK;
         pend_full <= 1'b0;
         disp      <= 8'h00;
         an        <= AN_OFF;
         seg       <= SEG_OFF;
      end else begin
         state <= state_nxt;
         disp  <= disp_nxt;
         if (transfer)    pend_full <= 1'b0;
         else if (accept) pend_full <= 1'b1;
         an  <= SEG_ACTIVE_LOW ? ~an_raw  : an_raw;
         seg <= SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
      end
   end

endmodule
